// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: CS setup, DATA_W bits MSB-first, CS hold, done pulse.
// All outputs are registered; pause freezes the serial clock only while shifting.
module spi_master_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [7:0]        bit_cnt_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                div_last;

    // Divider terminal count shared by SETUP, XFER and HOLD
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Next-state and next-output logic; outputs are set on the transition into each state
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_SETUP;
                    tx_sr_d   = tx_data_i;
                    mosi_d    = tx_data_i[DATA_W-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = '0;
                    bit_cnt_d = '0;
                end
            end

            S_SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_XFER;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_XFER: begin
                if (!pause_i) begin
                    if (div_last) begin
                        div_d = '0;
                        if (!sclk_q) begin
                            // Rising SCLK: sample slave data, count the bit
                            sclk_d    = 1'b1;
                            rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso_i};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end else begin
                            // Falling SCLK: present next bit, or finish after the last one
                            sclk_d = 1'b0;
                            if (bit_cnt_q < CNT_W'(DATA_W)) begin
                                tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                                mosi_d  = tx_sr_q[DATA_W-2];
                            end else begin
                                state_d = S_HOLD;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end

            S_HOLD: begin
                if (div_last) begin
                    div_d     = '0;
                    state_d   = S_FIN;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_FIN: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                mosi_d    = 1'b0;
                div_d     = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rx_data_o = rx_data_q;
    assign bit_cnt_o = bit_cnt_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl at DATA_W=8, CLK_DIV=4.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [7:0] tx_data;
    logic       miso;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic [7:0] bit_cnt;
    logic       sclk;
    logic       mosi;
    logic       cs_n;

    logic       miso_loop;
    logic       miso_val;

    int n_vec;
    int n_bad;

    // Edge and pulse observation state, updated by step()
    logic       sclk_prev;
    bit         rose;
    int         n_edge;
    int         n_rise;
    int         n_done;
    logic [7:0] mosi_bits;

    typedef struct {
        logic [7:0] tx;
        bit         loop;
        logic       mval;
        int         p_after;
        int         p_len;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .pause_i   (pause),
        .tx_data_i (tx_data),
        .miso_i    (miso),
        .busy_o    (busy),
        .done_o    (done),
        .rx_data_o (rx_data),
        .bit_cnt_o (bit_cnt),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .cs_n_o    (cs_n)
    );

    assign miso = miso_loop ? mosi : miso_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_obs();
        n_edge    = 0;
        n_rise    = 0;
        n_done    = 0;
        mosi_bits = '0;
        sclk_prev = sclk;
    endtask

    // Advance one clock and observe 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        rose = 1'b0;
        if (sclk !== sclk_prev) n_edge++;
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            rose      = 1'b1;
            n_rise++;
            mosi_bits = {mosi_bits[6:0], mosi};
        end
        sclk_prev = sclk;
        if (done === 1'b1) n_done++;
    endtask

    // One full transaction from a table record
    task automatic run_vec(input vec_t v);
        int         lat;
        int         pleft;
        bit         paused;
        bit         frozen_ok;
        logic       snap_sclk;
        logic [7:0] snap_cnt;
        tx_data   = v.tx;
        miso_loop = v.loop;
        miso_val  = v.mval;
        start     = 1'b1;
        clr_obs();
        step();
        start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        chk("cs_asserted", cs_n, 1'b0);
        chk("first_mosi", mosi, v.tx[7]);
        lat       = 0;
        pleft     = 0;
        paused    = 1'b0;
        frozen_ok = 1'b1;
        snap_sclk = 1'b0;
        snap_cnt  = '0;
        while (done !== 1'b1 && lat < 300) begin
            step();
            lat++;
            if (pleft > 0) begin
                if (sclk !== snap_sclk || bit_cnt !== snap_cnt) frozen_ok = 1'b0;
                pleft--;
                if (pleft == 0) pause = 1'b0;
            end else if (rose && v.p_len > 0 && !paused && n_rise == v.p_after) begin
                pause     = 1'b1;
                pleft     = v.p_len;
                paused    = 1'b1;
                snap_sclk = sclk;
                snap_cnt  = bit_cnt;
            end
        end
        pause = 1'b0;
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("rx_data", rx_data, v.exp_rx);
        chk("sclk_edges", 32'(n_edge), 32'd16);
        chk("mosi_bits", mosi_bits, v.tx);
        chk("bit_cnt_fin", bit_cnt, 8'd8);
        chk("busy_fin", busy, 1'b0);
        chk("cs_fin", cs_n, 1'b1);
        if (v.p_len > 0) begin
            chk("pause_frozen", 32'(frozen_ok), 32'd1);
            chk("pause_seen", 32'(paused), 32'd1);
        end
        step();
        chk("done_pulse_1cyc", done, 1'b0);
        chk("bit_cnt_idle", bit_cnt, 8'd0);
    endtask

    initial begin
        int lat;
        int g;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        tx_data   = '0;
        miso_loop = 1'b0;
        miso_val  = 1'b0;
        sclk_prev = 1'b0;
        clr_obs();

        vecs[0] = '{tx: 8'hA5, loop: 1'b1, mval: 1'b0, p_after: 0, p_len: 0,  exp_rx: 8'hA5, exp_lat: 72};
        vecs[1] = '{tx: 8'h3C, loop: 1'b0, mval: 1'b1, p_after: 0, p_len: 0,  exp_rx: 8'hFF, exp_lat: 72};
        vecs[2] = '{tx: 8'h81, loop: 1'b1, mval: 1'b0, p_after: 3, p_len: 10, exp_rx: 8'h81, exp_lat: 82};
        vecs[3] = '{tx: 8'h5A, loop: 1'b0, mval: 1'b0, p_after: 0, p_len: 0,  exp_rx: 8'h00, exp_lat: 72};
        vecs[4] = '{tx: 8'h01, loop: 1'b1, mval: 1'b0, p_after: 7, p_len: 3,  exp_rx: 8'h01, exp_lat: 75};

        // Reset state
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_bit_cnt", bit_cnt, 8'h00);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        rst_n = 1'b1;
        step();

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // start re-pulsed while busy is ignored and not queued
        tx_data   = 8'h12;
        miso_loop = 1'b1;
        start     = 1'b1;
        clr_obs();
        step();
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 110; c++) begin
            step();
            if (done === 1'b1 && lat < 0) lat = c;
            if (c == 5) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        chk("repulse_done_count", 32'(n_done), 32'd1);
        chk("repulse_latency", 32'(lat), 32'd72);
        chk("repulse_rx", rx_data, 8'h12);
        chk("repulse_not_queued", busy, 1'b0);

        // Reset in the middle of a transaction aborts it without done
        tx_data = 8'h33;
        start   = 1'b1;
        clr_obs();
        step();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_cs_n", cs_n, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_bit_cnt", bit_cnt, 8'h00);
        chk("abort_rx", rx_data, 8'h00);
        n_done = 0;
        for (int c = 0; c < 80; c++) step();
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_vec('{tx: 8'h6C, loop: 1'b1, mval: 1'b0, p_after: 0, p_len: 0, exp_rx: 8'h6C, exp_lat: 72});
        step();

        // Back-to-back with start held high; tx_data change after acceptance is ignored
        tx_data   = 8'hC3;
        miso_loop = 1'b1;
        start     = 1'b1;
        clr_obs();
        step();
        chk("b2b_busy1", busy, 1'b1);
        tx_data = 8'h96;
        lat     = 0;
        while (done !== 1'b1 && lat < 300) begin
            step();
            lat++;
        end
        chk("b2b_lat1", 32'(lat), 32'd72);
        chk("b2b_rx1", rx_data, 8'hC3);
        g = 0;
        while (busy !== 1'b1 && g < 10) begin
            step();
            g++;
        end
        start = 1'b0;
        chk("b2b_gap", 32'(g), 32'd2);
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            step();
            lat++;
        end
        chk("b2b_lat2", 32'(lat), 32'd72);
        chk("b2b_rx2", rx_data, 8'h96);
        repeat (5) step();
        chk("b2b_idle_after", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
